// File: rtl/decoder_sample_buffer_if.sv
// -----------------------------------------------------------------------------
// decoder_sample_buffer_if
// Groups the two handshakes of the decoder sample buffer:
//   input side : valid_i, samples_i (packed group), ready_o
//   output side: coeff_o, coeff_valid_o, coeff_ready_i, coeff_last_o
// Modports:
//   master : the agent driving groups in and consuming coefficients
//   slave  : the buffer itself
// -----------------------------------------------------------------------------
interface decoder_sample_buffer_if #(
   parameter int OUTPUT_W = 4,
   parameter int COEFF_W  = 23,
   parameter int OUT_W    = 32
);
   logic                         valid_i;
   logic [OUTPUT_W*COEFF_W-1:0]  samples_i;
   logic                         ready_o;
   logic [OUT_W-1:0]             coeff_o;
   logic                         coeff_valid_o;
   logic                         coeff_ready_i;
   logic                         coeff_last_o;

   modport master (
      output valid_i, samples_i, coeff_ready_i,
      input  ready_o, coeff_o, coeff_valid_o, coeff_last_o
   );

   modport slave (
      input  valid_i, samples_i, coeff_ready_i,
      output ready_o, coeff_o, coeff_valid_o, coeff_last_o
   );
endinterface

// File: rtl/decoder_sample_buffer.sv
// -----------------------------------------------------------------------------
// decoder_sample_buffer
// Output-side buffer for the decoder core. Packed coefficient groups are
// accepted over a valid/ready handshake into a DEPTH-entry FIFO, then an
// unpacker returns them one coefficient per beat, zero-extended to OUT_W.
// Emitted coefficients are counted (saturating) and a sticky done flag is
// raised when the count reaches a nonzero host-programmed target.
// Ports:
//   clk            : clock, rising edge
//   resetn         : synchronous active-low reset
//   clear_i        : synchronous flush (FIFO, unpacker, counter, done)
//   bus            : slave modport, group input and coefficient output
//   expected_cnt_i : coefficient target for done_o (0 = none)
//   fifo_count_o   : groups stored in the FIFO (not counting the unpacker)
//   coeff_cnt_o    : coefficients emitted, saturating at 0xFFFF
//   done_o         : sticky target-reached flag
// -----------------------------------------------------------------------------
module decoder_sample_buffer #(
   parameter int OUTPUT_W = 4,
   parameter int COEFF_W  = 23,
   parameter int DEPTH    = 16,
   parameter int OUT_W    = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     clear_i,
   decoder_sample_buffer_if.slave   bus,
   input  logic [15:0]              expected_cnt_i,
   output logic [$clog2(DEPTH):0]   fifo_count_o,
   output logic [15:0]              coeff_cnt_o,
   output logic                     done_o
);
   localparam int GROUP_W = OUTPUT_W * COEFF_W;
   localparam int AW      = $clog2(DEPTH);
   localparam int CW      = AW + 1;
   localparam int LW      = (OUTPUT_W > 1) ? $clog2(OUTPUT_W) : 1;
   localparam logic [LW-1:0] LAST_LANE = LW'(OUTPUT_W - 1);

   typedef enum logic {
      ST_EMPTY,
      ST_HOLD
   } state_t;

   // Flush from either source; overrides any handshake in the same cycle.
   logic flush;
   assign flush = !resetn || clear_i;

   // ---------------------------------------------------------------- FIFO
   logic [GROUP_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q;
   logic [AW-1:0]      rd_ptr_q;
   logic [CW-1:0]      count_q;
   logic [CW-1:0]      count_d;
   logic               fifo_empty;
   logic               push;
   logic               load;

   assign fifo_empty  = (count_q == '0);
   // Full check uses the registered count only, so a same-cycle pop never
   // opens the input.
   assign bus.ready_o = (count_q != CW'(DEPTH));
   assign push        = bus.valid_i && bus.ready_o;

   always_comb begin
      count_d = count_q;
      case ({push, load})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Power-of-two depth: pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (load) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Storage has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= bus.samples_i;
   end

   // ------------------------------------------------------------ Unpacker
   state_t             state_q;
   state_t             state_d;
   logic [LW-1:0]      lane_q;
   logic [LW-1:0]      lane_d;
   logic [GROUP_W-1:0] hold_q;

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      load    = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (!fifo_empty) begin
               load    = 1'b1;
               state_d = ST_HOLD;
               lane_d  = '0;
            end
         end
         ST_HOLD: begin
            if (bus.coeff_ready_i) begin
               if (lane_q == LAST_LANE) begin
                  lane_d = '0;
                  // Reload directly from the last lane so a full FIFO drains
                  // without a bubble between groups.
                  if (!fifo_empty) load = 1'b1;
                  else             state_d = ST_EMPTY;
               end else begin
                  lane_d = lane_q + LW'(1);
               end
            end
         end
         default: begin
            state_d = ST_EMPTY;
            lane_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         state_q <= ST_EMPTY;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
      end
   end

   // Registered read of the head entry straight into the hold register.
   always_ff @(posedge clk) begin
      if (load && !flush) hold_q <= mem_q[rd_ptr_q];
   end

   logic [COEFF_W-1:0] lanes [OUTPUT_W];
   generate
      for (genvar gi = 0; gi < OUTPUT_W; gi++) begin : g_lane
         assign lanes[gi] = hold_q[gi*COEFF_W +: COEFF_W];
      end
   endgenerate

   assign bus.coeff_valid_o = (state_q == ST_HOLD);
   assign bus.coeff_last_o  = bus.coeff_valid_o && (lane_q == LAST_LANE);
   // Gated so the output reads zero while empty, without resetting hold_q.
   assign bus.coeff_o       = bus.coeff_valid_o ? OUT_W'(lanes[lane_q]) : '0;

   // ------------------------------------------------------ Count and done
   logic        fire;
   logic [15:0] coeff_cnt_q;
   logic [15:0] coeff_cnt_d;
   logic        done_q;

   assign fire        = bus.coeff_valid_o && bus.coeff_ready_i;
   assign coeff_cnt_d = (&coeff_cnt_q) ? coeff_cnt_q : coeff_cnt_q + 16'd1;

   always_ff @(posedge clk) begin
      if (flush) begin
         coeff_cnt_q <= '0;
         done_q      <= 1'b0;
      end else if (fire) begin
         coeff_cnt_q <= coeff_cnt_d;
         if ((expected_cnt_i != 16'd0) && (coeff_cnt_d == expected_cnt_i))
            done_q <= 1'b1;
      end
   end

   assign fifo_count_o = count_q;
   assign coeff_cnt_o  = coeff_cnt_q;
   assign done_o       = done_q;
endmodule

// File: tb/tb_decoder_sample_buffer.sv
// -----------------------------------------------------------------------------
// tb_decoder_sample_buffer
// Directed self-checking bench for decoder_sample_buffer. Inputs are driven
// and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_decoder_sample_buffer;
   localparam int OUTPUT_W = 4;
   localparam int COEFF_W  = 23;
   localparam int DEPTH    = 16;
   localparam int OUT_W    = 32;
   localparam int GW       = OUTPUT_W * COEFF_W;

   logic        clk = 1'b0;
   logic        resetn;
   logic        clear_i;
   logic [15:0] expected_cnt_i;
   logic [4:0]  fifo_count_o;
   logic [15:0] coeff_cnt_o;
   logic        done_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decoder_sample_buffer_if #(.OUTPUT_W(OUTPUT_W), .COEFF_W(COEFF_W), .OUT_W(OUT_W)) bus ();

   decoder_sample_buffer #(
      .OUTPUT_W(OUTPUT_W), .COEFF_W(COEFF_W), .DEPTH(DEPTH), .OUT_W(OUT_W)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .clear_i        (clear_i),
      .bus            (bus),
      .expected_cnt_i (expected_cnt_i),
      .fifo_count_o   (fifo_count_o),
      .coeff_cnt_o    (coeff_cnt_o),
      .done_o         (done_o)
   );

   function automatic logic [COEFF_W-1:0] lane_val(int base, int g, int k);
      return COEFF_W'(base + g * OUTPUT_W + k);
   endfunction

   function automatic logic [GW-1:0] make_group(int base, int g);
      logic [GW-1:0] grp;
      grp = '0;
      for (int k = 0; k < OUTPUT_W; k++) grp[k*COEFF_W +: COEFF_W] = lane_val(base, g, k);
      return grp;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      clear_i = 1'b0;
      bus.valid_i = 1'b0;
      bus.samples_i = '0;
      bus.coeff_ready_i = 1'b0;
      expected_cnt_i = 16'd0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
      checks++; if (bus.coeff_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.coeff_valid_o); end
      checks++; if (bus.coeff_last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bus.coeff_last_o); end
      checks++; if (bus.coeff_o !== 32'h0) begin errors++; $display("FAIL reset_coeff: got %h want 0", bus.coeff_o); end
      checks++; if (fifo_count_o !== 5'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count_o); end
      checks++; if (coeff_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_coeff_cnt: got %0d want 0", coeff_cnt_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
      $display("test_reset: outputs sampled after reset");
   endtask

   task automatic test_single_group();
      logic [COEFF_W-1:0] exp_l [OUTPUT_W];
      logic [GW-1:0]      grp;
      logic [OUT_W-1:0]   exp_w [OUTPUT_W];
      exp_l = '{23'h000001, 23'h7FFFFF, 23'h123456, 23'h400000};
      exp_w = '{32'h00000001, 32'h007FFFFF, 32'h00123456, 32'h00400000};
      grp = '0;
      for (int k = 0; k < OUTPUT_W; k++) grp[k*COEFF_W +: COEFF_W] = exp_l[k];
      bus.samples_i = grp;
      bus.valid_i = 1'b1;
      bus.coeff_ready_i = 1'b1;
      tick();                      // acceptance edge
      bus.valid_i = 1'b0;
      checks++; if (bus.coeff_valid_o !== 1'b0) begin errors++; $display("FAIL single_latency: valid got %b want 0 one edge after accept", bus.coeff_valid_o); end
      checks++; if (fifo_count_o !== 5'd1) begin errors++; $display("FAIL single_count: got %0d want 1", fifo_count_o); end
      tick();                      // load edge
      for (int k = 0; k < OUTPUT_W; k++) begin
         $display("single: beat %0d coeff=%h valid=%b last=%b", k, bus.coeff_o, bus.coeff_valid_o, bus.coeff_last_o);
         checks++; if (bus.coeff_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid%0d: got %b want 1", k, bus.coeff_valid_o); end
         checks++; if (bus.coeff_o !== exp_w[k]) begin errors++; $display("FAIL single_coeff%0d: got %h want %h", k, bus.coeff_o, exp_w[k]); end
         checks++; if (bus.coeff_last_o !== (k == OUTPUT_W - 1)) begin errors++; $display("FAIL single_last%0d: got %b want %b", k, bus.coeff_last_o, (k == OUTPUT_W - 1)); end
         tick();
      end
      checks++; if (bus.coeff_valid_o !== 1'b0) begin errors++; $display("FAIL single_end_valid: got %b want 0", bus.coeff_valid_o); end
      checks++; if (bus.coeff_last_o !== 1'b0) begin errors++; $display("FAIL single_end_last: got %b want 0", bus.coeff_last_o); end
      bus.coeff_ready_i = 1'b0;
   endtask

   task automatic test_fill_full();
      int base;
      logic [COEFF_W-1:0] ev;
      base = 32'h100000;
      do_reset();
      for (int g = 0; g < 17; g++) begin
         bus.valid_i = 1'b1;
         bus.samples_i = make_group(base, g);
         checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b want 1", g, bus.ready_o); end
         $display("fill: push group %0d", g);
         tick();
      end
      bus.samples_i = make_group(base, 17);
      checks++; if (fifo_count_o !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d want 16", fifo_count_o); end
      checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready_full: got %b want 0", bus.ready_o); end
      ev = lane_val(base, 0, 0);
      checks++; if (bus.coeff_o !== OUT_W'(ev)) begin errors++; $display("FAIL fill_hold: got %h want %h", bus.coeff_o, OUT_W'(ev)); end
      tick();                      // 18th group offered while full
      bus.valid_i = 1'b0;
      checks++; if (fifo_count_o !== 5'd16) begin errors++; $display("FAIL fill_count_18: got %0d want 16", fifo_count_o); end
      bus.coeff_ready_i = 1'b1;
      for (int i = 0; i < 17 * OUTPUT_W; i++) begin
         ev = lane_val(base, i / OUTPUT_W, i % OUTPUT_W);
         $display("fill: out %0d coeff=%h valid=%b", i, bus.coeff_o, bus.coeff_valid_o);
         checks++; if (bus.coeff_valid_o !== 1'b1 || bus.coeff_o !== OUT_W'(ev)) begin
            errors++; $display("FAIL fill_out%0d: got valid=%b coeff=%h want valid=1 coeff=%h", i, bus.coeff_valid_o, bus.coeff_o, OUT_W'(ev));
         end
         checks++; if (bus.coeff_last_o !== ((i % OUTPUT_W) == OUTPUT_W - 1)) begin errors++; $display("FAIL fill_last%0d: got %b", i, bus.coeff_last_o); end
         tick();
      end
      checks++; if (bus.coeff_valid_o !== 1'b0) begin errors++; $display("FAIL fill_drained: valid got %b want 0", bus.coeff_valid_o); end
      checks++; if (coeff_cnt_o !== 16'd68) begin errors++; $display("FAIL fill_cnt: got %0d want 68", coeff_cnt_o); end
      bus.coeff_ready_i = 1'b0;
   endtask

   task automatic test_wrap();
      int base, in_idx, out_idx, cyc;
      logic [COEFF_W-1:0] ev;
      base = 32'h200000;
      in_idx = 0;
      out_idx = 0;
      cyc = 0;
      do_reset();
      while (cyc < 3000 && out_idx < 40 * OUTPUT_W) begin
         bus.coeff_ready_i = ($urandom_range(0, 1) == 1);
         bus.valid_i = (in_idx < 40) && ($urandom_range(0, 1) == 1);
         bus.samples_i = make_group(base, in_idx);
         if (bus.valid_i && bus.ready_o) in_idx++;
         if (bus.coeff_valid_o && bus.coeff_ready_i) begin
            ev = lane_val(base, out_idx / OUTPUT_W, out_idx % OUTPUT_W);
            $display("wrap: out %0d coeff=%h", out_idx, bus.coeff_o);
            checks++; if (bus.coeff_o !== OUT_W'(ev)) begin errors++; $display("FAIL wrap_out%0d: got %h want %h", out_idx, bus.coeff_o, OUT_W'(ev)); end
            out_idx++;
         end
         checks++; if (fifo_count_o > 5'd16) begin errors++; $display("FAIL wrap_count: got %0d want <=16", fifo_count_o); end
         tick();
         cyc++;
      end
      bus.valid_i = 1'b0;
      bus.coeff_ready_i = 1'b0;
      checks++; if (out_idx != 40 * OUTPUT_W) begin errors++; $display("FAIL wrap_timeout: got %0d coefficients want %0d", out_idx, 40 * OUTPUT_W); end
   endtask

   task automatic test_done();
      int n, pushed;
      do_reset();
      expected_cnt_i = 16'd8;
      bus.coeff_ready_i = 1'b1;
      n = 0;
      pushed = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         checks++; if (done_o !== (n >= 8)) begin errors++; $display("FAIL done_flag_c%0d: got %b want %b (consumed %0d)", cyc, done_o, (n >= 8), n); end
         checks++; if (coeff_cnt_o !== 16'(n)) begin errors++; $display("FAIL done_cnt_c%0d: got %0d want %0d", cyc, coeff_cnt_o, n); end
         bus.valid_i = (pushed < 3);
         bus.samples_i = make_group(32'h300000, pushed);
         if (bus.valid_i && bus.ready_o) pushed++;
         if (bus.coeff_valid_o && bus.coeff_ready_i) begin
            n++;
            $display("done: consumed %0d coeff=%h", n, bus.coeff_o);
         end
         tick();
      end
      bus.valid_i = 1'b0;
      checks++; if (coeff_cnt_o !== 16'd12) begin errors++; $display("FAIL done_final_cnt: got %0d want 12", coeff_cnt_o); end
      expected_cnt_i = 16'd0;
      tick();
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL done_sticky: got %b want 1", done_o); end

      // A zero target never sets done.
      do_reset();
      bus.coeff_ready_i = 1'b1;
      pushed = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         bus.valid_i = (pushed < 3);
         bus.samples_i = make_group(32'h300000, pushed);
         if (bus.valid_i && bus.ready_o) pushed++;
         checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL done_zero_c%0d: got %b want 0", cyc, done_o); end
         tick();
      end
      bus.valid_i = 1'b0;
      bus.coeff_ready_i = 1'b0;
      checks++; if (coeff_cnt_o !== 16'd12) begin errors++; $display("FAIL done_zero_cnt: got %0d want 12", coeff_cnt_o); end
   endtask

   task automatic test_clear();
      int base;
      logic [COEFF_W-1:0] ev;
      base = 32'h400000;
      do_reset();
      for (int g = 0; g < 5; g++) begin
         bus.valid_i = 1'b1;
         bus.samples_i = make_group(base, g);
         tick();
      end
      bus.valid_i = 1'b0;
      tick();
      checks++; if (fifo_count_o !== 5'd4) begin errors++; $display("FAIL clear_loaded: got %0d want 4", fifo_count_o); end
      bus.coeff_ready_i = 1'b1;
      tick();
      tick();
      bus.coeff_ready_i = 1'b0;
      ev = lane_val(base, 0, 2);
      checks++; if (coeff_cnt_o !== 16'd2) begin errors++; $display("FAIL clear_pre_cnt: got %0d want 2", coeff_cnt_o); end
      checks++; if (bus.coeff_o !== OUT_W'(ev)) begin errors++; $display("FAIL clear_pre_lane: got %h want %h", bus.coeff_o, OUT_W'(ev)); end
      clear_i = 1'b1;
      bus.valid_i = 1'b1;
      bus.samples_i = make_group(base, 9);
      bus.coeff_ready_i = 1'b1;
      tick();
      clear_i = 1'b0;
      bus.valid_i = 1'b0;
      bus.coeff_ready_i = 1'b0;
      $display("clear: pulsed with a push");
      checks++; if (bus.coeff_valid_o !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b want 0", bus.coeff_valid_o); end
      checks++; if (fifo_count_o !== 5'd0) begin errors++; $display("FAIL clear_count: got %0d want 0", fifo_count_o); end
      checks++; if (coeff_cnt_o !== 16'd0) begin errors++; $display("FAIL clear_cnt: got %0d want 0", coeff_cnt_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL clear_done: got %b want 0", done_o); end
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL clear_ready: got %b want 1", bus.ready_o); end
      tick();
      tick();
      checks++; if (bus.coeff_valid_o !== 1'b0) begin errors++; $display("FAIL clear_dropped: valid got %b want 0", bus.coeff_valid_o); end
      bus.valid_i = 1'b1;
      bus.samples_i = make_group(base, 7);
      bus.coeff_ready_i = 1'b1;
      tick();
      bus.valid_i = 1'b0;
      tick();
      ev = lane_val(base, 7, 0);
      $display("clear: new group first coeff=%h", bus.coeff_o);
      checks++; if (bus.coeff_valid_o !== 1'b1 || bus.coeff_o !== OUT_W'(ev)) begin
         errors++; $display("FAIL clear_new_lane0: got valid=%b coeff=%h want valid=1 coeff=%h", bus.coeff_valid_o, bus.coeff_o, OUT_W'(ev));
      end
      for (int k = 0; k < OUTPUT_W; k++) tick();
      checks++; if (coeff_cnt_o !== 16'd4) begin errors++; $display("FAIL clear_new_cnt: got %0d want 4", coeff_cnt_o); end
      bus.coeff_ready_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      int base;
      logic [COEFF_W-1:0] ev;
      base = 32'h500000;
      do_reset();
      for (int g = 0; g < 2; g++) begin
         bus.valid_i = 1'b1;
         bus.samples_i = make_group(base, g);
         tick();
      end
      bus.valid_i = 1'b0;
      bus.coeff_ready_i = 1'b1;
      tick();
      tick();
      bus.coeff_ready_i = 1'b0;
      ev = lane_val(base, 0, 2);
      checks++; if (bus.coeff_o !== OUT_W'(ev)) begin errors++; $display("FAIL rstmid_lane2: got %h want %h", bus.coeff_o, OUT_W'(ev)); end
      resetn = 1'b0;
      bus.coeff_ready_i = 1'b1;
      tick();
      resetn = 1'b1;
      bus.coeff_ready_i = 1'b0;
      $display("reset_mid: reset applied in HOLD(2)");
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", bus.ready_o); end
      checks++; if (bus.coeff_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", bus.coeff_valid_o); end
      checks++; if (bus.coeff_last_o !== 1'b0) begin errors++; $display("FAIL rstmid_last: got %b want 0", bus.coeff_last_o); end
      checks++; if (bus.coeff_o !== 32'h0) begin errors++; $display("FAIL rstmid_coeff: got %h want 0", bus.coeff_o); end
      checks++; if (fifo_count_o !== 5'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", fifo_count_o); end
      checks++; if (coeff_cnt_o !== 16'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d want 0", coeff_cnt_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done_o); end
      tick();
      tick();
      checks++; if (bus.coeff_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_stays_empty: got %b want 0", bus.coeff_valid_o); end
   endtask

   initial begin
      resetn = 1'b0;
      clear_i = 1'b0;
      expected_cnt_i = 16'd0;
      bus.valid_i = 1'b0;
      bus.samples_i = '0;
      bus.coeff_ready_i = 1'b0;
      test_reset();
      test_single_group();
      test_fill_full();
      test_wrap();
      test_done();
      test_clear();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/decoder_sample_buffer.md
# decoder_sample_buffer

Output-side buffer for the decoder core: accepts packed coefficient groups (`OUTPUT_W` × `COEFF_W` bits) over the decoder's valid/ready handshake and stores them in a FIFO. It returns them one coefficient per beat, zero-extended to 32 bits, to the host interface register readout. It back-pressures the decoder when full, counts emitted coefficients against a host-programmed target, and raises a sticky done flag. It sits between the decoder's `samples`/`valid_o`/`ready_i` and the host interface, in the crypto clock domain.

## Interface
- `OUTPUT_W`, 4: coefficients per input group.
- `COEFF_W`, 23: bits per coefficient.
- `DEPTH`, 16: FIFO entries (groups). Must be a power of 2, ≥ 2.
- `OUT_W`, 32: output coefficient width. Must be ≥ `COEFF_W`.
- `clk`  in  1  crypto clock; all logic on the rising edge.
- `resetn`  in  1  **synchronous, active-low reset.**
- `clear_i`  in  1  synchronous flush of FIFO, unpacker, counters and done flag.
- `valid_i`  in  1  input group valid (from decoder `valid_o`).
- `samples_i`  in  `OUTPUT_W*COEFF_W`  packed group; lane k = bits [k*COEFF_W +: COEFF_W].
- `ready_o`  out  1  buffer can accept (to decoder `ready_i`).
- `expected_cnt_i`  in  16  number of coefficients that completes a job; 0 = no target.
- `coeff_o`  out  `OUT_W`  current coefficient, zero-extended.
- `coeff_valid_o`  out  1  `coeff_o` valid.
- `coeff_ready_i`  in  1  host consumes `coeff_o`.
- `coeff_last_o`  out  1  current coefficient is lane `OUTPUT_W-1` of its group.
- `fifo_count_o`  out  clog2(`DEPTH`)+1  groups stored in the FIFO (excludes the group in the unpacker).
- `coeff_cnt_o`  out  16  coefficients emitted since reset/clear; saturates at 0xFFFF.
- `done_o`  out  1  sticky: `coeff_cnt_o` reached a nonzero `expected_cnt_i`.

## Operation
- **Input accept:** an input is accepted when `valid_i && ready_o` at an edge. The group is written at `wr_ptr` and `wr_ptr` increments modulo `DEPTH`. `ready_o` = FIFO not full.
- `ready_o` does not depend on a same-cycle pop. When the FIFO is full, no write occurs even if a pop happens that cycle.
- **Unpacker states:**
  - EMPTY: no group held.
  - HOLD(lane): a group is held and `lane` (0..`OUTPUT_W-1`) selects the output coefficient.
- **Unpacker transitions:**
  - EMPTY, FIFO non-empty: load head group into the hold register, go to HOLD(0), pop the FIFO.
  - HOLD(lane < last) with `coeff_ready_i`: go to HOLD(lane+1).
  - HOLD(last) with `coeff_ready_i`: if the FIFO is non-empty, load the next group into HOLD(0) and pop in the same edge (no bubble). Otherwise go to EMPTY.
  - Without `coeff_ready_i`: state and `coeff_o` hold stable.
- **Output mapping:**
  - `coeff_valid_o` = state is HOLD.
  - `coeff_o` = {zeros, hold[lane]}.
  - `coeff_last_o` = HOLD(`OUTPUT_W-1`).
- **Counting:** each `coeff_valid_o && coeff_ready_i` increments `coeff_cnt_o`, saturating at 0xFFFF.
- **Done flag:** `done_o` sets on the edge where the incremented count equals `expected_cnt_i` and `expected_cnt_i != 0`. It stays set until reset or clear.
  - Coefficients beyond the target still flow and count.
  - Changing `expected_cnt_i` does not clear `done_o`.
- **Simultaneous push and pop:** a push with a FIFO pop in the same cycle leaves `fifo_count_o` unchanged. Pointers wrap modulo `DEPTH`.
- **Clear/reset:** `resetn` low or `clear_i` high at an edge zeroes both pointers, the count, `coeff_cnt_o` and `done_o`, and sets EMPTY.
  - Clear/reset overrides any same-cycle push or pop; that handshake is discarded.
  - Partially consumed groups are discarded.
  - Memory contents need no reset.

## Timing
- **Reset values:**
  - `ready_o`=1 (combinational from count=0).
  - `coeff_valid_o`=0, `coeff_last_o`=0, `coeff_o`=0.
  - `fifo_count_o`=0, `coeff_cnt_o`=0, `done_o`=0.
- **Latency:** a group accepted at edge N is loaded at edge N+1 (from EMPTY). `coeff_valid_o` is high in the cycle after edge N+1, so first coefficient is visible 2 edges after acceptance. There is no write-to-read bypass.
- **Throughput:** 1 coefficient per cycle with `coeff_ready_i` held high. An input rate of 1 group per `OUTPUT_W` cycles is sustained without back-pressure.
- **Combinational paths:** `ready_o` is a function of registered count only. No combinational path from `valid_i` or `coeff_ready_i` to any output.
- All outputs other than `ready_o` are registered or decoded from registered state.

## Test plan
- **Reset, single group:** after reset, push one group with lanes 0x000001, 0x7FFFFF, 0x123456, 0x400000 and keep `coeff_ready_i`=1.
  - `coeff_valid_o` rises 2 edges after acceptance.
  - Outputs are 0x00000001, 0x007FFFFF, 0x00123456, 0x00400000 on consecutive cycles.
  - `coeff_last_o` is high on the 4th output only; then `coeff_valid_o`=0.
- **Fill to full:** with `coeff_ready_i`=0, push 17 groups.
  - The FIFO holds 16 groups plus one in the unpacker (17 accepted).
  - Check `fifo_count_o` = 16 and `ready_o`=0; the 18th `valid_i` is not accepted.
  - Release `coeff_ready_i`: all 68 coefficients come out in order with no gaps.
- **Wrap-around and simultaneous push/pop:** stream 40 incrementing groups with random `valid_i` and `coeff_ready_i` (50%).
  - Output order matches input order across pointer wrap.
  - `fifo_count_o` never exceeds 16.
- **Done:** set `expected_cnt_i`=8 and send 3 groups.
  - `done_o` rises on the edge of the 8th consumed coefficient and stays high while coefficients 9–12 drain.
  - `coeff_cnt_o` ends at 12.
  - `expected_cnt_i`=0 never sets `done_o`.
- **Clear mid-operation:** load 5 groups, consume 2 coefficients, then pulse `clear_i` together with `valid_i`.
  - The pushed group is dropped.
  - Next cycle: `coeff_valid_o`=0, `fifo_count_o`=0, `coeff_cnt_o`=0, `done_o`=0.
  - A new group afterwards is emitted starting at lane 0.
- **Reset mid-stream:** assert `resetn`=0 for one edge while in HOLD(2).
  - All outputs return to reset values.
  - `ready_o`=1 immediately after.
